mu0_io_bridge: RTL and testbench
================================

// Module: mu0_io_bridge
// PURPOSE
//  Bus bridge between the MU0 core memory port and system memory.
//  - Most addresses pass straight through to memory.
//  - Addresses IO_BASE..IO_BASE+15 are decoded to a small I/O page.
//  - The I/O page holds a TX FIFO feeding an 8N1 serial transmitter, plus status/count registers.
//  - Provides the core's only output channel; the core sees a zero-wait-state bus.
// PARAMETERS
//  IO_BASE       12'hFF0  base of 16-word I/O page; bits [3:0] must be 0
//  FIFO_DEPTH    4        TX FIFO entries; power of 2, >=2
//  CLKS_PER_BIT  16       Clk cycles per serial bit; >=2
// PORTS
//  Clk        in   1   system clock, rising edge
//  Reset      in   1   asynchronous, active-low reset
//  cpu_addr   in   12  core address (core Addr)
//  cpu_dout   in   16  core write data (core Dout)
//  cpu_rd     in   1   core read strobe
//  cpu_wr     in   1   core write strobe
//  cpu_din    out  16  read data to core (core Din)
//  mem_addr   out  12  memory address, = cpu_addr
//  mem_wdata  out  16  memory write data, = cpu_dout
//  mem_rd     out  1   memory read strobe
//  mem_wr     out  1   memory write strobe
//  mem_rdata  in   16  memory read data
//  tx         out  1   serial output, idle high
//  tx_busy    out  1   transmitter not IDLE
// BEHAVIOUR
//  Decode and memory path:
//  - io_sel = (cpu_addr[11:4] == IO_BASE[11:4]).
//  - Decode and the memory path are combinational.
//  - mem_rd = cpu_rd & ~io_sel; mem_wr = cpu_wr & ~io_sel.
//  - cpu_din = io_sel ? io_rdata : mem_rdata. io_rdata is combinational from registers.
//  I/O map (word offsets):
//  - +0 TXDATA: write pushes cpu_dout[7:0]; read returns 0.
//  - +1 STATUS: read {12'b0, ovf, empty, busy, full}.
//      Any write clears ovf.
//  - +2 COUNT: read FIFO occupancy, zero-extended; writes are ignored.
//  - +3..+15: read 0; writes are ignored.
//  - I/O writes take effect at the Clk edge where cpu_wr=1.
//  Reset (Reset=0, async):
//  - FIFO empty, ovf=0, FSM=IDLE, bit counters 0.
//  - tx=1 immediately, tx_busy=0.
//  - A frame in flight is aborted, not completed.
//  FIFO rules:
//  - push = TXDATA write; pop = FSM load.
//  - Push while full with no pop: data dropped, ovf set (sticky).
//  - Push and pop in the same cycle when full: push accepted, count unchanged.
//  - Push and pop in the same cycle when empty cannot occur; pop requires !empty.
//  - Pointers wrap modulo FIFO_DEPTH.
//  - full = (count==FIFO_DEPTH); empty = (count==0).
//  TX FSM (tx is registered):
//  - IDLE: tx=1. If !empty: pop into shift reg, go to START.
//  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
//  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, then STOP.
//  - STOP: tx=1 for CLKS_PER_BIT cycles.
//      If !empty at the last cycle: pop and go directly to START (no idle gap).
//      Otherwise go to IDLE.
//  - tx_busy = (state != IDLE).
//  - Frame length is exactly 10*CLKS_PER_BIT cycles.
//  Latency:
//  - A TXDATA write at edge N with FSM IDLE and FIFO empty gives FIFO count=1 after N.
//  - The FSM pops at edge N+1; tx falls after edge N+1.
//  Simultaneous events:
//  - STATUS write (clear) and an overflowing push in the same cycle leave ovf=1.
//  - cpu_rd and cpu_wr both high: the write is honoured and cpu_din is still driven.
// TESTING
//  1. Reset mid-frame: write 8'hA5, drop Reset during DATA -> tx=1 at once, COUNT=0, busy=0.
//  2. Single byte, CLKS_PER_BIT=4: write 16'h00A5 to FF0 -> tx low 1 cycle after the write.
//     Then bits 1,0,1,0,0,1,0,1 at 4 clk each, stop; busy low after 40 clk.
//  3. Overflow: 6 back-to-back writes 01..06 while the first frame is pending.
//     -> after write 6: COUNT=4, STATUS[3]=1.
//     -> frames emitted 01..05; 06 dropped.
//     Then a STATUS write -> STATUS[3]=0.
//  4. Back-to-back: 3 queued bytes -> tx shows no idle cycles between stop and next start.
//     Total 120 clk at CLKS_PER_BIT=4.
//  5. Pass-through: R/W 0x000, 0xFEF, 0xFFF.
//     -> mem_rd/mem_wr asserted only for 0x000 and 0xFEF.
//     -> read of 0xFF3 returns 0; read of 0xFEF returns mem_rdata.
//  6. Full plus pop: push at the FSM pop cycle while full -> accepted, COUNT stays 4, ovf=0.

Source files
------------

// File: rtl/mu0_io_bridge_if.sv
// Bus bundle between the MU0 core port, system memory and the I/O page.
// cpu_rd / cpu_wr are the valid strobes and the bridge is always ready, so any strobe
// sampled high at a rising Clk completes in that cycle (zero wait states).
interface mu0_io_bridge_if;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_dout;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_din;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        tx;
  logic        tx_busy;
  logic [1:0]  tx_state;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_rd, cpu_wr, mem_rdata,
    output cpu_din, mem_addr, mem_wdata, mem_rd, mem_wr, tx, tx_busy, tx_state
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_rd, cpu_wr, mem_rdata,
    input  cpu_din, mem_addr, mem_wdata, mem_rd, mem_wr, tx, tx_busy, tx_state
  );
endinterface

// File: rtl/mu0_io_bridge.sv
// MU0 memory-port bridge: pass-through to memory plus a 16-word I/O page holding a
// TX FIFO, an 8N1 serial transmitter and status/count registers.
module mu0_io_bridge #(
  parameter logic [11:0] IO_BASE      = 12'hFF0,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  mu0_io_bridge_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  logic        io_sel;
  logic [3:0]  io_off;
  logic        push;
  logic        stat_wr;
  logic [15:0] io_rdata;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          full;
  logic          empty;
  logic          pop;
  logic          accept;
  logic          drop;

  tx_state_t     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          tx_q, tx_n;

  assign io_sel  = (bus.cpu_addr[11:4] == IO_BASE[11:4]);
  assign io_off  = bus.cpu_addr[3:0];
  assign push    = io_sel & bus.cpu_wr & (io_off == 4'd0);
  assign stat_wr = io_sel & bus.cpu_wr & (io_off == 4'd1);

  assign bus.mem_addr  = bus.cpu_addr;
  assign bus.mem_wdata = bus.cpu_dout;
  assign bus.mem_rd    = bus.cpu_rd & ~io_sel;
  assign bus.mem_wr    = bus.cpu_wr & ~io_sel;
  assign bus.cpu_din   = io_sel ? io_rdata : bus.mem_rdata;

  assign bus.tx       = tx_q;
  assign bus.tx_busy  = (state != IDLE);
  assign bus.tx_state = state;

  always_comb begin
    io_rdata = '0;
    case (io_off)
      4'd1:    io_rdata = {12'b0, ovf, empty, bus.tx_busy, full};
      4'd2:    io_rdata = 16'(count);
      default: io_rdata = '0;
    endcase
  end

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge Clk) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= bus.cpu_dout[7:0];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A dropped push wins over a same-cycle clear so the overflow is never lost.
      if (drop) begin
        ovf <= 1'b1;
      end else if (stat_wr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    sh_n    = shreg;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = fifo_mem[rd_ptr];
          baud_n  = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            // The next bit to send is shreg[1], which becomes shreg[0] after the shift.
            bit_n = bit_idx + 3'd1;
            sh_n  = {1'b0, shreg[7:1]};
            tx_n  = shreg[1];
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            sh_n    = fifo_mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_mu0_io_bridge.sv
// Bench for mu0_io_bridge: directed scenarios plus random bus traffic, checked every
// cycle against a frame-timeline model of the transmitter and a byte queue for the FIFO.
module tb_mu0_io_bridge;
  localparam int C = 4;
  localparam int D = 4;
  localparam logic [11:0] BASE = 12'hFF0;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  mu0_io_bridge_if bus();

  mu0_io_bridge #(.IO_BASE(BASE), .FIFO_DEPTH(D), .CLKS_PER_BIT(C)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: queued bytes, plus the edge at which the current frame began.
  logic [7:0] exp_q[$];
  bit         in_frame = 1'b0;
  int         frame_start = 0;
  logic [7:0] cur_byte = 8'h00;
  bit         ovf_m = 1'b0;

  int rise_cyc = 0;
  int fall_cyc = 0;
  bit prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_io(input logic [11:0] addr);
    return (int'(addr) >= int'(BASE)) && (int'(addr) <= int'(BASE) + 15);
  endfunction

  function automatic logic exp_tx();
    int k;
    int slot;
    if (!in_frame) return 1'b1;
    k = cyc - frame_start;
    slot = k / C;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return cur_byte[slot-1];
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_read(input logic [11:0] addr, input logic [15:0] mrd);
    int off;
    if (!is_io(addr)) return mrd;
    off = int'(addr) - int'(BASE);
    if (off == 1) return {12'b0, ovf_m, exp_q.size() == 0, in_frame, exp_q.size() == D};
    if (off == 2) return 16'(exp_q.size());
    return 16'h0000;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    in_frame = 1'b0;
    ovf_m = 1'b0;
  endfunction

  // Event order at one edge: frame end, then pop into a new frame, then the bus write.
  function automatic void model_edge();
    int off;
    if (in_frame && (cyc - frame_start == 10 * C)) in_frame = 1'b0;
    if (!in_frame && exp_q.size() > 0) begin
      cur_byte = exp_q.pop_front();
      frame_start = cyc;
      in_frame = 1'b1;
    end
    if (bus.cpu_wr && is_io(bus.cpu_addr)) begin
      off = int'(bus.cpu_addr) - int'(BASE);
      if (off == 0) begin
        if (exp_q.size() < D) exp_q.push_back(bus.cpu_dout[7:0]);
        else ovf_m = 1'b1;
      end else if (off == 1) begin
        ovf_m = 1'b0;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge Clk);
    if (Reset) begin
      cyc++;
      model_edge();
    end
    #1;
    if (Reset) begin
      chk("tx", bus.tx, exp_tx());
      chk("tx_busy", bus.tx_busy, in_frame);
      if (bus.tx_busy && !prev_busy) rise_cyc = cyc;
      if (!bus.tx_busy && prev_busy) fall_cyc = cyc;
      prev_busy = bus.tx_busy;
    end
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [15:0] data);
    bus.cpu_addr = addr;
    bus.cpu_dout = data;
    bus.cpu_wr = 1'b1;
    bus.cpu_rd = 1'b0;
    #1;
    chk("mem_wr", bus.mem_wr, !is_io(addr));
    chk("mem_addr", bus.mem_addr, addr);
    chk("mem_wdata", bus.mem_wdata, data);
    cycle();
    bus.cpu_wr = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] addr);
    bus.cpu_addr = addr;
    bus.cpu_rd = 1'b1;
    bus.cpu_wr = 1'b0;
    bus.mem_rdata = 16'($urandom);
    #1;
    chk("mem_rd", bus.mem_rd, !is_io(addr));
    chk("cpu_din", bus.cpu_din, model_read(addr, bus.mem_rdata));
    cycle();
    bus.cpu_rd = 1'b0;
  endtask

  task automatic do_rw(input logic [11:0] addr, input logic [15:0] data);
    bus.cpu_addr = addr;
    bus.cpu_dout = data;
    bus.cpu_rd = 1'b1;
    bus.cpu_wr = 1'b1;
    bus.mem_rdata = 16'($urandom);
    #1;
    chk("rw_mem_rd", bus.mem_rd, !is_io(addr));
    chk("rw_mem_wr", bus.mem_wr, !is_io(addr));
    chk("rw_cpu_din", bus.cpu_din, model_read(addr, bus.mem_rdata));
    cycle();
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic peek(input logic [11:0] addr, output logic [15:0] v);
    bus.cpu_addr = addr;
    bus.cpu_rd = 1'b1;
    bus.cpu_wr = 1'b0;
    #1;
    v = bus.cpu_din;
    bus.cpu_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((in_frame || exp_q.size() > 0) && n < 2000) begin
      cycle();
      n++;
    end
    chk("drain_bound", n < 2000, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [7:0] bits;
    logic [11:0] addr;
    int cnt;
    int r;
    logic [11:0] pt_addr [3];

    bus.cpu_addr = '0;
    bus.cpu_dout = '0;
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_busy", bus.tx_busy, 1'b0);
    peek(BASE + 12'd1, v);
    chk("rst_status", v, 16'h0004);
    peek(BASE + 12'd2, v);
    chk("rst_count", v, 16'h0000);
    @(negedge Clk);
    Reset = 1'b1;
    cycle();

    // Single byte A5: start bit right after the pop, LSB-first data, 40-cycle frame
    do_write(BASE, 16'h00A5);
    cycle();
    chk("t2_start_tx", bus.tx, 1'b0);
    chk("t2_start_busy", bus.tx_busy, 1'b1);
    bits = 8'hA5;
    cnt = 0;
    while (bus.tx_busy && cnt < 200) begin
      cycle();
      cnt++;
      if ((cnt % C == 2) && (cnt / C >= 1) && (cnt / C <= 8))
        chk("t2_bit", bus.tx, bits[cnt / C - 1]);
    end
    chk("t2_len", 16'(cnt), 16'd40);

    // Reset mid-frame
    wait_idle();
    do_write(BASE, 16'h00A5);
    repeat (10) cycle();
    chk("t1_mid_busy", bus.tx_busy, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    chk("t1_rst_tx", bus.tx, 1'b1);
    chk("t1_rst_busy", bus.tx_busy, 1'b0);
    model_reset();
    prev_busy = 1'b0;
    peek(BASE + 12'd2, v);
    chk("t1_rst_count", v, 16'h0000);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) cycle();

    // Overflow: six back-to-back pushes, sixth dropped
    for (int i = 1; i <= 6; i++) do_write(BASE, 16'(i));
    peek(BASE + 12'd2, v);
    chk("t3_count", v, 16'd4);
    peek(BASE + 12'd1, v);
    chk("t3_ovf_set", v[3], 1'b1);
    chk("t3_model_status", v, model_read(BASE + 12'd1, 16'h0));
    do_write(BASE + 12'd1, 16'hFFFF);
    peek(BASE + 12'd1, v);
    chk("t3_ovf_clr", v[3], 1'b0);
    wait_idle();

    // Back-to-back frames: one busy span of 3 frames
    cycle();
    do_write(BASE, 16'h003C);
    do_write(BASE, 16'h00C3);
    do_write(BASE, 16'h0081);
    cnt = 0;
    while (bus.tx_busy && cnt < 300) begin
      cycle();
      cnt++;
    end
    chk("t4_span", 16'(fall_cyc - rise_cyc), 16'd120);

    // Pass-through and I/O page reads
    pt_addr[0] = 12'h000;
    pt_addr[1] = 12'hFEF;
    pt_addr[2] = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      do_write(pt_addr[i], 16'($urandom));
      do_read(pt_addr[i]);
    end
    peek(BASE + 12'd3, v);
    chk("t5_ff3", v, 16'h0000);
    bus.mem_rdata = 16'h5A3C;
    peek(12'hFEF, v);
    chk("t5_fef", v, 16'h5A3C);

    // Full FIFO plus a push landing on the STOP-end pop
    wait_idle();
    do_write(BASE, 16'h0011);
    do_write(BASE, 16'h0022);
    do_write(BASE, 16'h0033);
    do_write(BASE, 16'h0044);
    do_write(BASE, 16'h0055);
    cnt = 0;
    while (!(in_frame && (cyc + 1 - frame_start == 10 * C)) && cnt < 500) begin
      cycle();
      cnt++;
    end
    chk("t6_bound", cnt < 500, 1'b1);
    do_write(BASE, 16'h0066);
    peek(BASE + 12'd2, v);
    chk("t6_count", v, 16'd4);
    peek(BASE + 12'd1, v);
    chk("t6_ovf", v[3], 1'b0);
    chk("t6_full", v[0], 1'b1);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        addr = BASE + 12'($urandom_range(0, 3));
        do_write(addr, 16'($urandom));
      end else if (r <= 5) begin
        do_read(BASE + 12'($urandom_range(0, 15)));
      end else if (r == 6) begin
        do_write(12'($urandom), 16'($urandom));
      end else if (r == 7) begin
        do_read(12'($urandom));
      end else if (r == 8) begin
        addr = ($urandom_range(0, 1) == 1) ? BASE + 12'($urandom_range(0, 15)) : 12'($urandom);
        do_rw(addr, 16'($urandom));
      end else begin
        cycle();
      end
    end
    wait_idle();
    cycle();
    chk("end_busy", bus.tx_busy, 1'b0);
    peek(BASE + 12'd2, v);
    chk("end_count", v, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
